exception_detector: RTL and testbench

// - Decode-stage trap detector for the RV32I core (no C extension).
// - Classifies the current instruction as no trap, EBREAK, ECALL or

---
 rtl/exception_detector.sv | 79 +++++++
 tb/tb_exception_detector.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/exception_detector.sv
// rtl/exception_detector.sv - decode-stage trap classifier with combinational and registered outputs
module exception_detector (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       imm_0,
  input  logic [1:0] jump_target_lsbs,
  input  logic       branch,
  input  logic [1:0] branch_target_lsbs,
  output logic       trapped,
  output logic [1:0] trap_status,
  output logic       trapped_q,
  output logic [1:0] trap_status_q
);

  // Opcode values used by the classifier
  localparam logic [6:0] OP_RTYPE       = 7'b0110011;
  localparam logic [6:0] OP_ENVIRONMENT = 7'b1110011;
  localparam logic [6:0] OP_BRANCH      = 7'b1100011;
  localparam logic [6:0] OP_JAL         = 7'b1101111;
  localparam logic [6:0] OP_JALR        = 7'b1100111;

  // Trap cause encoding seen by the trap controller
  localparam logic [1:0] ST_NONE       = 2'b00;
  localparam logic [1:0] ST_EBREAK     = 2'b01;
  localparam logic [1:0] ST_ECALL      = 2'b10;
  localparam logic [1:0] ST_MISALIGNED = 2'b11;

  // Status is the single source of truth; trapped is derived from it so the
  // two outputs can never disagree.
  logic [1:0] status_c;

  // Classify the current instruction; each opcode arm only looks at its own fields
  always_comb begin
    status_c = ST_NONE;
    case (opcode)
      OP_ENVIRONMENT: begin
        // funct3 != 000 are CSR accesses, which never trap here
        if (funct3 == 3'b000) begin
          status_c = imm_0 ? ST_EBREAK : ST_ECALL;
        end
      end
      OP_BRANCH: begin
        // A not-taken branch never redirects, so its target is irrelevant
        if (branch && (branch_target_lsbs != 2'b00)) begin
          status_c = ST_MISALIGNED;
        end
      end
      OP_JAL, OP_JALR: begin
        // JALR bit-0 clearing happens upstream; lsbs are checked as received
        if (jump_target_lsbs != 2'b00) begin
          status_c = ST_MISALIGNED;
        end
      end
      OP_RTYPE: begin
        status_c = ST_NONE;
      end
      default: begin
        status_c = ST_NONE;
      end
    endcase
  end

  assign trap_status = status_c;
  assign trapped     = (status_c != ST_NONE);

  // One-cycle registered copy for the trap/CSR write path
  always_ff @(posedge clk) begin
    if (reset) begin
      trapped_q     <= 1'b0;
      trap_status_q <= ST_NONE;
    end else begin
      trapped_q     <= trapped;
      trap_status_q <= trap_status;
    end
  end

endmodule

// File: tb/tb_exception_detector.sv
// tb/tb_exception_detector.sv - scoreboard bench for exception_detector
module tb_exception_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       imm_0;
  logic [1:0] jump_target_lsbs;
  logic       branch;
  logic [1:0] branch_target_lsbs;
  logic       trapped;
  logic [1:0] trap_status;
  logic       trapped_q;
  logic [1:0] trap_status_q;

  always #5 clk = ~clk;

  exception_detector dut (
    .clk                (clk),
    .reset              (reset),
    .opcode             (opcode),
    .funct3             (funct3),
    .imm_0              (imm_0),
    .jump_target_lsbs   (jump_target_lsbs),
    .branch             (branch),
    .branch_target_lsbs (branch_target_lsbs),
    .trapped            (trapped),
    .trap_status        (trap_status),
    .trapped_q          (trapped_q),
    .trap_status_q      (trap_status_q)
  );

  localparam logic [6:0] RT = 7'h33, EN = 7'h73, BR = 7'h63, JL = 7'h6F, JR = 7'h67;
  localparam logic [6:0] LD = 7'h03, ST = 7'h23, LU = 7'h37;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic       i0;
    logic [1:0] jl;
    logic       br;
    logic [1:0] bl;
    logic       exp_t;
    logic [1:0] exp_s;
  } vec_t;

  typedef struct {
    logic [2:0] comb;
    logic [2:0] regd;
    int         idx;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   driver_done = 0;

  // Hand-computed vectors: rst, opcode, funct3, imm_0, jump lsbs, branch, branch lsbs, trapped, status
  vec_t vecs[] = '{
    '{1, RT, 3'd0, 0, 2'd0, 0, 2'd0, 0, 2'b00},
    '{1, RT, 3'd0, 0, 2'd0, 0, 2'd0, 0, 2'b00},
    '{0, EN, 3'd0, 1, 2'd0, 0, 2'd0, 1, 2'b01},
    '{0, EN, 3'd0, 0, 2'd0, 0, 2'd0, 1, 2'b10},
    '{0, EN, 3'd1, 1, 2'd0, 0, 2'd0, 0, 2'b00},
    '{0, BR, 3'd0, 0, 2'd0, 0, 2'd0, 0, 2'b00},
    '{0, BR, 3'd0, 0, 2'd0, 0, 2'd1, 0, 2'b00},
    '{0, BR, 3'd0, 0, 2'd0, 1, 2'd0, 0, 2'b00},
    '{0, BR, 3'd0, 0, 2'd0, 1, 2'd1, 1, 2'b11},
    '{0, BR, 3'd0, 0, 2'd0, 1, 2'd2, 1, 2'b11},
    '{0, JL, 3'd0, 0, 2'd0, 0, 2'd0, 0, 2'b00},
    '{0, JL, 3'd0, 0, 2'd1, 0, 2'd0, 1, 2'b11},
    '{0, JR, 3'd0, 0, 2'd0, 0, 2'd0, 0, 2'b00},
    '{0, JR, 3'd0, 0, 2'd1, 0, 2'd0, 1, 2'b11},
    '{0, JR, 3'd0, 0, 2'd2, 1, 2'd3, 1, 2'b11},
    '{0, RT, 3'd0, 1, 2'd3, 1, 2'd3, 0, 2'b00},
    '{0, EN, 3'd0, 0, 2'd3, 1, 2'd1, 1, 2'b10},
    '{1, EN, 3'd0, 0, 2'd0, 0, 2'd0, 1, 2'b10},
    '{1, EN, 3'd0, 0, 2'd0, 0, 2'd0, 1, 2'b10},
    '{0, EN, 3'd0, 0, 2'd0, 0, 2'd0, 1, 2'b10},
    '{0, RT, 3'd0, 0, 2'd0, 0, 2'd0, 0, 2'b00},
    '{0, LD, 3'd0, 1, 2'd1, 1, 2'd1, 0, 2'b00},
    '{0, ST, 3'd0, 1, 2'd3, 1, 2'd2, 0, 2'b00},
    '{0, LU, 3'd0, 1, 2'd1, 1, 2'd3, 0, 2'b00},
    '{0, BR, 3'd5, 1, 2'd0, 1, 2'd3, 1, 2'b11},
    '{0, EN, 3'd2, 0, 2'd1, 1, 2'd1, 0, 2'b00}
  };

  // Independent reference used only for the random sweep
  function automatic logic [2:0] ref_model(input logic [6:0] op, input logic [2:0] f3,
                                           input logic i0, input logic [1:0] jl,
                                           input logic br, input logic [1:0] bl);
    logic [2:0] r;
    r = 3'b000;
    if (op == EN && f3 == 3'd0) r = i0 ? 3'b101 : 3'b110;
    else if (op == BR && br && bl != 2'd0) r = 3'b111;
    else if ((op == JL || op == JR) && jl != 2'd0) r = 3'b111;
    return r;
  endfunction

  // Driver: apply one vector just after each rising edge and push the expectation
  initial begin
    logic       prev_rst;
    logic [2:0] prev_comb;
    logic [2:0] ecomb;
    exp_t       e;
    reset = 1'b1; opcode = RT; funct3 = 0; imm_0 = 0;
    jump_target_lsbs = 0; branch = 0; branch_target_lsbs = 0;
    prev_rst = 1'b1;
    prev_comb = 3'b000;
    for (int i = 0; i < vecs.size() + 200; i++) begin
      @(posedge clk);
      #1;
      if (i < vecs.size()) begin
        reset = vecs[i].rst; opcode = vecs[i].op; funct3 = vecs[i].f3; imm_0 = vecs[i].i0;
        jump_target_lsbs = vecs[i].jl; branch = vecs[i].br; branch_target_lsbs = vecs[i].bl;
        ecomb = {vecs[i].exp_t, vecs[i].exp_s};
      end else begin
        reset = ($urandom_range(15) == 0);
        case ($urandom_range(7))
          0: opcode = RT; 1: opcode = EN; 2: opcode = BR; 3: opcode = JL;
          4: opcode = JR; 5: opcode = LD; 6: opcode = ST;
          default: opcode = 7'($urandom_range(127));
        endcase
        funct3 = 3'($urandom_range(7)); imm_0 = 1'($urandom_range(1));
        jump_target_lsbs = 2'($urandom_range(3)); branch = 1'($urandom_range(1));
        branch_target_lsbs = 2'($urandom_range(3));
        if ($urandom_range(1) == 0) funct3 = 3'd0;
        ecomb = ref_model(opcode, funct3, imm_0, jump_target_lsbs, branch, branch_target_lsbs);
      end
      e.comb = ecomb;
      e.regd = prev_rst ? 3'b000 : prev_comb;
      e.idx  = i;
      sb.push_back(e);
      prev_rst  = reset;
      prev_comb = ecomb;
    end
    driver_done = 1;
  end

  // Monitor: on each falling edge pop the pending expectation and compare
  initial begin
    exp_t e;
    int   guard;
    guard = 0;
    while (!(driver_done && sb.size() == 0) && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({trapped, trap_status} !== e.comb) begin
          errors++;
          $display("FAIL comb[%0d]: got trapped=%b status=%b, want trapped=%b status=%b",
                   e.idx, trapped, trap_status, e.comb[2], e.comb[1:0]);
        end
        checks++;
        if ({trapped_q, trap_status_q} !== e.regd) begin
          errors++;
          $display("FAIL reg[%0d]: got trapped_q=%b status_q=%b, want trapped_q=%b status_q=%b",
                   e.idx, trapped_q, trap_status_q, e.regd[2], e.regd[1:0]);
        end
        checks++;
        if (trapped !== (trap_status != 2'b00)) begin
          errors++;
          $display("FAIL invariant[%0d]: got trapped=%b status=%b, want trapped==(status!=0)",
                   e.idx, trapped, trap_status);
        end
      end
    end
    checks++;
    if (!(driver_done && sb.size() == 0)) begin
      errors++;
      $display("FAIL timeout: got %0d pending expectations, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
